fetch_issue: RTL



---
 rtl/fetch_issue_pkg.sv | 26 ++
 rtl/fetch_issue_if.sv | 65 ++++++
 rtl/fetch_timeout_ctr.sv | 39 +++
 rtl/fetch_issue.sv | 122 ++++++++++++
 4 files changed

// File: rtl/fetch_issue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_issue_pkg
// Shared definitions for the fetch/issue slice: fetch FSM state encoding, the
// halt opcode, and the widths of the branch-offset fields sliced out of the
// fetched instruction.
// No ports (package).
// -----------------------------------------------------------------------------
package fetch_issue_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_HOLD = 3'd3,
        ST_ERR  = 3'd4,
        ST_HALT = 3'd5
    } state_t;

    // All-ones instruction; stops fetching when FETCH_HALT_EN is defined.
    localparam logic [15:0] HALT_OPCODE = 16'hFFFF;

    localparam int COND_W   = 8;
    localparam int UNCOND_W = 11;
    localparam int LINK_W   = 6;

endpackage

// File: rtl/fetch_issue_if.sv
// -----------------------------------------------------------------------------
// fetch_issue_if
// Bundles the instruction-memory read handshake, the decode handshake, the
// next-PC input and the status outputs of fetch_issue.
// Modports:
//   master - the fetch unit (drives imem request, instr/npc/fields, status)
//   slave  - the environment (memory, decode, next-PC logic)
// Signals:
//   imem_req_valid/imem_req_ready/imem_addr    read request channel
//   imem_rsp_valid/imem_rsp_data               read response channel
//   instr_valid/instr_ready/instr/npc          decode handshake + payload
//   cond_address/uncond_address/link_address   instruction field slices
//   next_pc                                    next PC, sampled on accept
//   fetch_err                                  sticky response-timeout flag
//   halted                                     only with FETCH_HALT_EN defined
// -----------------------------------------------------------------------------
interface fetch_issue_if #(
    parameter int ADDR_W  = 16,
    parameter int INSTR_W = 16
);
    import fetch_issue_pkg::*;

    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [ADDR_W-1:0]   imem_addr;
    logic                imem_rsp_valid;
    logic [INSTR_W-1:0]  imem_rsp_data;
    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic [ADDR_W-1:0]   npc;
    logic [COND_W-1:0]   cond_address;
    logic [UNCOND_W-1:0] uncond_address;
    logic [LINK_W-1:0]   link_address;
    logic [ADDR_W-1:0]   next_pc;
    logic                fetch_err;
`ifdef FETCH_HALT_EN
    logic                halted;
`endif

    modport master (
`ifdef FETCH_HALT_EN
        output halted,
`endif
        output imem_req_valid, imem_addr,
        output instr_valid, instr, npc,
        output cond_address, uncond_address, link_address,
        output fetch_err,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  instr_ready, next_pc
    );

    modport slave (
`ifdef FETCH_HALT_EN
        input  halted,
`endif
        input  imem_req_valid, imem_addr,
        input  instr_valid, instr, npc,
        input  cond_address, uncond_address, link_address,
        input  fetch_err,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output instr_ready, next_pc
    );

endinterface

// File: rtl/fetch_timeout_ctr.sv
// -----------------------------------------------------------------------------
// fetch_timeout_ctr
// Clear/enable up-counter with a terminal-count flag, used to bound the wait
// for an instruction-memory response.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   i_clear     - synchronous clear (has priority over i_enable)
//   i_enable    - count up by one
//   o_terminal  - count equals TIMEOUT-1
// -----------------------------------------------------------------------------
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_terminal
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_terminal = (r_count == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/fetch_issue.sv
// -----------------------------------------------------------------------------
// fetch_issue
// Owns the architectural PC, fetches the instruction at PC over a valid/ready
// request + valid response memory interface, holds it for decode together
// with its address (npc) and branch-offset field slices, and loads next_pc
// when decode accepts. A missing response for TIMEOUT cycles sets the sticky
// fetch_err and parks the FSM until reset.
// Optional macro FETCH_HALT_EN: accepting the all-ones instruction parks the
// FSM in HALT (PC not updated) and drives the extra bus.halted output.
// Ports:
//   clk    - system clock
//   reset  - asynchronous active-high reset
//   bus    - fetch_issue_if.master (memory, decode, next-PC, status signals)
// -----------------------------------------------------------------------------
module fetch_issue
    import fetch_issue_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                INSTR_W  = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000,
    parameter int                TIMEOUT  = 64
) (
    input  logic          clk,
    input  logic          reset,
    fetch_issue_if.master bus
);

    state_t               r_state;
    state_t               w_next_state;
    logic [ADDR_W-1:0]    r_pc;
    logic [INSTR_W-1:0]   r_instr;
    logic                 r_fetch_err;
    logic                 w_timeout;
    logic                 w_rsp;
    logic                 w_accept;
    logic                 w_is_halt;

    // Responses and accepts only count in the state that expects them.
    assign w_rsp    = (r_state == ST_WAIT) && bus.imem_rsp_valid;
    assign w_accept = (r_state == ST_HOLD) && bus.instr_ready;

`ifdef FETCH_HALT_EN
    assign w_is_halt = (r_instr == INSTR_W'(HALT_OPCODE));
`else
    assign w_is_halt = 1'b0;
`endif

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout_ctr (
        .clk        (clk),
        .reset      (reset),
        .i_clear    ((r_state != ST_WAIT) || bus.imem_rsp_valid),
        .i_enable   (r_state == ST_WAIT),
        .o_terminal (w_timeout)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so every path drives the signal and
        // no latch is inferred.
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: w_next_state = ST_REQ;
            ST_REQ:  if (bus.imem_req_ready) w_next_state = ST_WAIT;
            ST_WAIT: begin
                // A response in the terminal-count cycle still wins.
                if (bus.imem_rsp_valid) w_next_state = ST_HOLD;
                else if (w_timeout)     w_next_state = ST_ERR;
            end
            ST_HOLD: if (w_accept) w_next_state = w_is_halt ? ST_HALT : ST_REQ;
            default: w_next_state = r_state;  // ERR and HALT wait for reset
        endcase
    end

    // Output logic (Moore)
    always_comb begin
        bus.imem_req_valid = (r_state == ST_REQ);
        bus.instr_valid    = (r_state == ST_HOLD);
`ifdef FETCH_HALT_EN
        bus.halted         = (r_state == ST_HALT);
`endif
    end

    // Datapath: PC, held instruction, sticky error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_fetch_err <= 1'b0;
        end else begin
            if (w_rsp) begin
                r_instr <= bus.imem_rsp_data;
            end
            if (w_accept && !w_is_halt) begin
                r_pc <= bus.next_pc;
            end
            if ((r_state == ST_WAIT) && !bus.imem_rsp_valid && w_timeout) begin
                r_fetch_err <= 1'b1;
            end
        end
    end

    // PC only moves on accept, so it is also the address of the held instr.
    assign bus.imem_addr      = r_pc;
    assign bus.npc            = r_pc;
    assign bus.instr          = r_instr;
    assign bus.cond_address   = r_instr[COND_W-1:0];
    assign bus.uncond_address = r_instr[UNCOND_W-1:0];
    assign bus.link_address   = r_instr[LINK_W-1:0];
    assign bus.fetch_err      = r_fetch_err;

endmodule
